pm_reduce_serial: RTL and testbench
===================================

PM_REDUCE_SERIAL -- requirements
Module: pm_reduce_serial

Interface
REQ-001 Parameter N, default 255: modulus exponent; p = 2^N - C.
REQ-002 Parameter C, default 19: modulus offset; SHALL satisfy 0 < C < 2^(N-1).
REQ-003 Parameter CW, default 5: bit width of C; SHALL satisfy 2^(CW-1) <= C < 2^CW.
REQ-004 Parameter IW, default 512: input width; SHALL satisfy N < IW <= 2N+2.
REQ-005 clk  in  1  clock; all state changes on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1  input operand valid.
REQ-008 in_ready  out  1  block can accept; equals (state == IDLE).
REQ-009 in_data  in  IW  unsigned operand to reduce.
REQ-010 in_partial  in  1  1 = lazy result in [0, 2^N); 0 = fully reduced result in [0, p).
REQ-011 out_valid  out  1  result valid, held until accepted.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 out_data  out  N  reduced result.
REQ-014 out_folds  out  3  number of fold passes used for out_data.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States SHALL be IDLE, CHECK, MUL, FOLD, OUT; internal accumulator x is IW+1 bits.
REQ-017 IDLE: on in_valid && in_ready, the block SHALL load x = in_data, latch in_partial, clear the fold count and go to CHECK.
REQ-018 CHECK, x[IW:N] != 0: the block SHALL load hi = x[IW:N] and lo = x[N-1:0], clear acc, set the bit counter to CW-1 and go to MUL.
REQ-019 CHECK, x[IW:N] == 0: out_data SHALL be x - p if partial == 0 and x >= p, else x; the block SHALL assert out_valid and go to OUT.
REQ-020 MUL: each cycle acc SHALL become (acc << 1) + (C[bit] ? hi : 0), MSB first; after CW cycles (bit 0 done) the block SHALL go to FOLD.
REQ-021 FOLD: x SHALL become lo + acc, the fold count SHALL increment (saturating at 7), and the block SHALL go to CHECK.
REQ-022 Latency from acceptance edge to out_valid high SHALL be 1 + k*(CW+2) cycles for k folds; default parameters give k <= 3, i.e. at most 22 cycles.
REQ-023 OUT: out_data, out_folds and out_valid SHALL hold stable while out_ready is low; on out_valid && out_ready the block SHALL clear out_valid and return to IDLE.
REQ-024 in_ready SHALL be low in OUT even when out_ready is high; the next operand is accepted no earlier than the cycle after the result handshake.
REQ-025 in_data and in_partial SHALL be ignored outside IDLE; changes during busy SHALL NOT affect the result.
REQ-026 Sums in FOLD and the multiply SHALL NOT overflow x/acc for any legal parameter set; arithmetic SHALL be unsigned.
REQ-027 Result SHALL equal in_data mod p when partial == 0, and be congruent to in_data mod p and below 2^N when partial == 1.

Reset
REQ-028 On reset the block SHALL go to IDLE with out_valid = 0, out_data = 0, out_folds = 0, busy = 0, in_ready = 1, and x, acc, hi, lo and the counters cleared.
REQ-029 Reset asserted in any state, including mid-MUL or OUT, SHALL abandon the operation with no out_valid pulse; in_ready SHALL be high on the first cycle after reset is released.

Verification
REQ-030 in_data = 0, partial = 0 -> out_data = 0, out_folds = 0, out_valid 1 cycle after acceptance.
REQ-031 in_data = 2^255-19 -> partial = 0: out_data = 0; partial = 1: out_data = 2^255-19; out_folds = 0, latency 1.
REQ-032 in_data = 2^255 -> out_data = 19, out_folds = 1, latency 8.
REQ-033 in_data = 2^512-1 -> out_data = 1443, out_folds = 3, latency 22.
REQ-034 out_ready held low 5 cycles after out_valid -> out_data stable, in_ready = 0, and in_valid pulses ignored; handshake on cycle 6, then in_ready = 1.
REQ-035 Reset pulsed during MUL of in_data = 2^511 -> all outputs zero, no out_valid; a new operand 2^255+5 then yields 24 with folds = 1.

Source files
------------

// File: rtl/pm_reduce_serial.sv
// Serial reduction modulo p = 2^N - C: folds x = hi*2^N + lo into lo + hi*C until x < 2^N,
// with hi*C formed by a shift-and-add over the CW bits of C, MSB first.
module pm_reduce_serial #(
  parameter int N  = 255,
  parameter int C  = 19,
  parameter int CW = 5,
  parameter int IW = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [IW-1:0] in_data,
  input  logic          in_partial,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_data,
  output logic [2:0]    out_folds,
  output logic          busy
);

  localparam int XW = IW + 1;                // accumulator width
  localparam int HW = XW - N;                // width of the high part x[IW:N]
  localparam int AW = HW + CW;               // hi * C < 2^(HW+CW)
  localparam int BW = (CW > 1) ? $clog2(CW) : 1;

  localparam logic [CW-1:0] C_VEC = CW'(C);
  localparam logic [N-1:0]  P_VAL = ~N'(0) - N'(C - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL,
    S_FOLD,
    S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [HW-1:0]  hi_q, hi_d;
  logic [N-1:0]   lo_q, lo_d;
  logic [AW-1:0]  acc_q, acc_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [2:0]     folds_q, folds_d;
  logic           partial_q, partial_d;
  logic           out_valid_q, out_valid_d;
  logic [N-1:0]   out_data_q, out_data_d;
  logic [2:0]     out_folds_q, out_folds_d;

  // NOTE: every flop, datapath included, is cleared by the synchronous reset so that an
  // abandoned operation leaves no residue visible on the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      acc_q       <= '0;
      bit_q       <= '0;
      folds_q     <= '0;
      partial_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_folds_q <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      acc_q       <= acc_d;
      bit_q       <= bit_d;
      folds_q     <= folds_d;
      partial_q   <= partial_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_folds_q <= out_folds_d;
    end
  end

  // NOTE: every _d defaults to its _q before the case statement, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    acc_d       = acc_q;
    bit_d       = bit_q;
    folds_d     = folds_q;
    partial_d   = partial_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_folds_d = out_folds_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d       = {1'b0, in_data};
          partial_d = in_partial;
          folds_d   = '0;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        if (|x_q[XW-1:N]) begin
          hi_d    = x_q[XW-1:N];
          lo_d    = x_q[N-1:0];
          acc_d   = '0;
          bit_d   = BW'(CW - 1);
          state_d = S_MUL;
        end else begin
          // x < 2^N here, so one conditional subtraction completes the reduction
          if (!partial_q && (x_q[N-1:0] >= P_VAL)) begin
            out_data_d = x_q[N-1:0] - P_VAL;
          end else begin
            out_data_d = x_q[N-1:0];
          end
          out_folds_d = folds_q;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end

      S_MUL: begin
        acc_d = {acc_q[AW-2:0], 1'b0} + (C_VEC[bit_q] ? {{CW{1'b0}}, hi_q} : '0);
        if (bit_q == '0) begin
          state_d = S_FOLD;
        end else begin
          bit_d = bit_q - BW'(1);
        end
      end

      S_FOLD: begin
        x_d     = {{(XW-N){1'b0}}, lo_q} + {{(XW-AW){1'b0}}, acc_q};
        folds_d = (folds_q == 3'd7) ? folds_q : folds_q + 3'd1;
        state_d = S_CHECK;
      end

      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_folds = out_folds_q;

endmodule

// File: tb/tb_pm_reduce_serial.sv
// Directed bench for pm_reduce_serial with default parameters (p = 2^255 - 19):
// hand-computed residues, fold counts, latencies, backpressure and mid-operation reset.
module tb_pm_reduce_serial;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [511:0] in_data;
  logic         in_partial;
  logic         out_valid;
  logic         out_ready;
  logic [254:0] out_data;
  logic [2:0]   out_folds;
  logic         busy;

  int total = 0;
  int bad   = 0;

  pm_reduce_serial #(.N(255), .C(19), .CW(5), .IW(512)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_partial(in_partial),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_folds (out_folds),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Submit one operand, measure latency, optionally hold off the result for hold cycles.
  task automatic run_op(input string tag, input logic [511:0] data, input logic partial,
                        input logic [511:0] exp_data, input int exp_folds, input int exp_lat,
                        input int hold);
    int lat;
    int wait_cnt;
    logic [254:0] first_data;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 50) begin
      tick();
      wait_cnt++;
    end
    check({tag, ".ready"}, 512'(in_ready), 512'd1);
    in_data    = data;
    in_partial = partial;
    in_valid   = 1'b1;
    tick();
    in_valid   = 1'b0;
    // scramble inputs while busy; the result must not depend on them
    in_data    = ~data;
    in_partial = ~partial;
    lat = 0;
    while (!out_valid && lat < 60) begin
      tick();
      lat++;
    end
    check({tag, ".lat"},   512'(lat),       512'(exp_lat));
    check({tag, ".data"},  512'(out_data),  exp_data);
    check({tag, ".folds"}, 512'(out_folds), 512'(exp_folds));
    first_data = out_data;
    for (int i = 0; i < hold; i++) begin
      in_valid = (i % 2 == 0);
      tick();
      check({tag, ".hold_valid"}, 512'(out_valid), 512'd1);
      check({tag, ".hold_data"},  512'(out_data),  512'(first_data));
      check({tag, ".hold_ready"}, 512'(in_ready),  512'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".post_valid"}, 512'(out_valid), 512'd0);
    check({tag, ".post_ready"}, 512'(in_ready),  512'd1);
  endtask

  initial begin
    logic [511:0] p;
    logic [511:0] v;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_partial = 1'b0;
    out_ready  = 1'b0;
    p = (512'd1 << 255) - 512'd19;
    tick();
    tick();
    reset = 1'b0;
    check("rst.valid", 512'(out_valid), 512'd0);
    check("rst.data",  512'(out_data),  512'd0);
    check("rst.folds", 512'(out_folds), 512'd0);
    check("rst.busy",  512'(busy),      512'd0);
    check("rst.ready", 512'(in_ready),  512'd1);

    run_op("zero",     512'd0, 1'b0, 512'd0, 0, 1, 0);
    run_op("p_full",   p,      1'b0, 512'd0, 0, 1, 0);
    run_op("p_lazy",   p,      1'b1, p,      0, 1, 0);
    v = (512'd1 << 255) - 512'd1;
    run_op("max_full", v,      1'b0, 512'd18, 0, 1, 0);
    run_op("max_lazy", v,      1'b1, v,       0, 1, 0);
    run_op("pow255",   512'd1 << 255, 1'b0, 512'd19, 1, 8, 0);
    run_op("pow300",   512'd1 << 300, 1'b0, 512'd19 << 45, 1, 8, 0);
    run_op("all1",     ~512'd0, 1'b0, 512'd1443, 3, 22, 0);
    run_op("all1_lazy", ~512'd0, 1'b1, 512'd1443, 3, 22, 0);
    run_op("backpress", 512'd1 << 255, 1'b0, 512'd19, 1, 8, 5);

    // reset in the middle of the multiply
    in_data    = 512'd1 << 511;
    in_partial = 1'b0;
    in_valid   = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst.valid", 512'(out_valid), 512'd0);
    check("midrst.data",  512'(out_data),  512'd0);
    check("midrst.folds", 512'(out_folds), 512'd0);
    check("midrst.busy",  512'(busy),      512'd0);
    check("midrst.ready", 512'(in_ready),  512'd1);
    for (int i = 0; i < 25; i++) begin
      tick();
      check("midrst.no_valid", 512'(out_valid), 512'd0);
    end
    run_op("after_rst", (512'd1 << 255) + 512'd5, 1'b0, 512'd24, 1, 8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
